// File: rtl/userind.sv
`default_nettype none
// ============================================================================
// Module   : userind
// Purpose  : LED pattern driver (ACK flash, busy blink, done, error blink).
// Revision : 1.0
// ============================================================================
module userind #(
    parameter logic [15:0] TICKDIV  = 16'd50000,
    parameter logic [7:0]  ACKTIME  = 8'd100,
    parameter logic [7:0]  SLOWHALF = 8'd250,
    parameter logic [7:0]  FASTHALF = 8'd50,
    parameter logic [7:0]  DONEHOLD = 8'd255
) (
    input  logic       clk,
    input  logic       dreset,
    input  logic       dread,
    input  logic       rbusy,
    input  logic       rdone,
    input  logic       rerr,
    output logic       ledact,
    output logic       ledok,
    output logic       lederr,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACK  = 3'd1,
        S_BUSY = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  tick_q,  tick_d;
    logic        phase_q, phase_d;
    logic        tick;

    assign tick = (presc_q == (TICKDIV - 16'd1));

    always_comb begin
        state_d = state_q;
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        tick_d  = tick_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (dread) state_d = S_ACK;
            end
            S_ACK: begin
                if (rerr)                            state_d = S_ERR;
                else if (tick && tick_q == ACKTIME - 8'd1) state_d = S_BUSY;
                else if (tick)                       tick_d  = tick_q + 8'd1;
            end
            S_BUSY: begin
                if (rerr)        state_d = S_ERR;
                else if (rdone)  state_d = S_DONE;
                else if (!rbusy) state_d = S_ERR;
                else if (tick) begin
                    if (tick_q == SLOWHALF - 8'd1) begin
                        tick_d  = 8'd0;
                        phase_d = ~phase_q;
                    end else begin
                        tick_d  = tick_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                if (dread)                                  state_d = S_ACK;
                else if (tick && tick_q == DONEHOLD - 8'd1) state_d = S_IDLE;
                else if (tick)                              tick_d  = tick_q + 8'd1;
            end
            S_ERR: begin
                if (dread) state_d = S_IDLE;
                else if (tick) begin
                    if (tick_q == FASTHALF - 8'd1) begin
                        tick_d  = 8'd0;
                        phase_d = ~phase_q;
                    end else begin
                        tick_d  = tick_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Every state entry restarts timing with the LED phase on.
        if (state_d != state_q) begin
            presc_d = 16'd0;
            tick_d  = 8'd0;
            phase_d = 1'b1;
        end
    end

    always_ff @(negedge clk or negedge dreset) begin
        if (!dreset) begin
            state_q <= S_IDLE;
            presc_q <= 16'd0;
            tick_q  <= 8'd0;
            phase_q <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
        end
    end

    assign ledact = (state_q == S_ACK) || ((state_q == S_BUSY) && phase_q);
    assign ledok  = (state_q == S_DONE);
    assign lederr = (state_q == S_ERR) && phase_q;
    assign state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_userind.sv
`default_nettype none
// ============================================================================
// Module   : tb_userind
// Purpose  : Directed self-checking bench for userind LED patterns.
// Revision : 1.0
// ============================================================================
module tb_userind;

    logic       clk;
    logic       dreset;
    logic       dread;
    logic       rbusy;
    logic       rdone;
    logic       rerr;
    logic       ledact;
    logic       ledok;
    logic       lederr;
    logic [2:0] state;

    int r_errs;
    int r_checks;

    // Observation word: {state, ledact, ledok, lederr}
    localparam logic [5:0] c_IDLE     = {3'd0, 3'b000};
    localparam logic [5:0] c_ACK      = {3'd1, 3'b100};
    localparam logic [5:0] c_BUSY_ON  = {3'd2, 3'b100};
    localparam logic [5:0] c_BUSY_OFF = {3'd2, 3'b000};
    localparam logic [5:0] c_DONE     = {3'd3, 3'b010};
    localparam logic [5:0] c_ERR_ON   = {3'd4, 3'b001};
    localparam logic [5:0] c_ERR_OFF  = {3'd4, 3'b000};

    userind #(
        .TICKDIV (16'd4),
        .ACKTIME (8'd2),
        .SLOWHALF(8'd3),
        .FASTHALF(8'd1),
        .DONEHOLD(8'd5)
    ) u_dut (
        .clk   (clk),
        .dreset(dreset),
        .dread (dread),
        .rbusy (rbusy),
        .rdone (rdone),
        .rerr  (rerr),
        .ledact(ledact),
        .ledok (ledok),
        .lederr(lederr),
        .state (state)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errs++;
            $display("FAIL %s: got state=%0d leds(act,ok,err)=%b expected state=%0d leds=%b at %0t",
                     tag, got[5:3], got[2:0], exp[5:3], exp[2:0], $time);
        end
    endtask

    function automatic logic [5:0] obs();
        return {state, ledact, ledok, lederr};
    endfunction

    // Advance past the next active (falling) edge.
    task automatic edge1();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_n(input string tag, input int n, input logic [5:0] exp);
        for (int i = 0; i < n; i++) begin
            edge1();
            check(tag, obs(), exp);
        end
    endtask

    task automatic pulse_dread(input string tag, input logic [5:0] exp);
        dread = 1'b1;
        edge1();
        dread = 1'b0;
        check(tag, obs(), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        r_errs   = 0;
        r_checks = 0;
        dreset   = 1'b0;
        dread    = 1'b0;
        rbusy    = 1'b0;
        rdone    = 1'b0;
        rerr     = 1'b0;
        #1;
        check("reset_async", obs(), c_IDLE);

        // Inputs pulsed while held in reset must have no effect.
        dread = 1'b1; rbusy = 1'b1; rdone = 1'b1; rerr = 1'b1;
        expect_n("reset_hold", 3, c_IDLE);
        dread = 1'b0; rbusy = 1'b0; rdone = 1'b0; rerr = 1'b0;
        expect_n("reset_hold2", 2, c_IDLE);
        dreset = 1'b1;
        expect_n("idle", 50, c_IDLE);

        // Normal read
        pulse_dread("ack_entry", c_ACK);
        rbusy = 1'b1;
        expect_n("ack", 7, c_ACK);
        expect_n("busy_entry", 1, c_BUSY_ON);
        expect_n("busy_on", 11, c_BUSY_ON);
        expect_n("busy_off", 12, c_BUSY_OFF);
        expect_n("busy_on2", 1, c_BUSY_ON);
        rdone = 1'b1;
        edge1();
        rdone = 1'b0;
        rbusy = 1'b0;
        check("done_entry", obs(), c_DONE);
        expect_n("done", 19, c_DONE);
        expect_n("done_timeout", 1, c_IDLE);

        // Error during ACK, with rerr held two cycles
        pulse_dread("ack2", c_ACK);
        rerr = 1'b1;
        edge1();
        check("err_entry", obs(), c_ERR_ON);
        edge1();
        rerr = 1'b0;
        check("err_rerr_held", obs(), c_ERR_ON);
        expect_n("err_on", 2, c_ERR_ON);
        expect_n("err_off", 4, c_ERR_OFF);
        expect_n("err_on2", 1, c_ERR_ON);
        pulse_dread("err_exit", c_IDLE);

        // Lost core in BUSY
        pulse_dread("ack3", c_ACK);
        rbusy = 1'b1;
        expect_n("ack3", 7, c_ACK);
        expect_n("busy3", 3, c_BUSY_ON);
        rbusy = 1'b0;
        expect_n("lost_core", 1, c_ERR_ON);
        pulse_dread("err_exit2", c_IDLE);

        // rerr beats rdone
        pulse_dread("ack4", c_ACK);
        rbusy = 1'b1;
        expect_n("ack4", 7, c_ACK);
        expect_n("busy4", 2, c_BUSY_ON);
        rerr = 1'b1; rdone = 1'b1;
        edge1();
        rerr = 1'b0; rdone = 1'b0;
        check("prio_rerr_rdone", obs(), c_ERR_ON);
        pulse_dread("err_exit3", c_IDLE);

        // dread beats DONE timeout on the same edge
        pulse_dread("ack5", c_ACK);
        expect_n("ack5", 7, c_ACK);
        expect_n("busy5", 1, c_BUSY_ON);
        rdone = 1'b1;
        edge1();
        rdone = 1'b0;
        check("done5", obs(), c_DONE);
        expect_n("done5", 19, c_DONE);
        pulse_dread("prio_dread_timeout", c_ACK);
        expect_n("ack6", 7, c_ACK);
        expect_n("busy6", 1, c_BUSY_ON);

        // Re-arm from DONE after 10 cycles
        rdone = 1'b1;
        edge1();
        rdone = 1'b0;
        check("done7", obs(), c_DONE);
        expect_n("done7", 9, c_DONE);
        pulse_dread("rearm", c_ACK);
        expect_n("rearm_ack", 7, c_ACK);
        expect_n("rearm_busy", 1, c_BUSY_ON);

        // Asynchronous reset between edges mid-blink
        expect_n("busy8", 2, c_BUSY_ON);
        #3;
        dreset = 1'b0;
        #1;
        check("reset_mid_blink", obs(), c_IDLE);
        expect_n("reset_mid_hold", 1, c_IDLE);
        #2;
        dreset = 1'b1;
        expect_n("post_reset_idle", 2, c_IDLE);
        pulse_dread("post_reset_ack", c_ACK);
        expect_n("post_reset_ack", 7, c_ACK);
        expect_n("post_reset_busy", 1, c_BUSY_ON);
        rbusy = 1'b0;

        $display("Result: errors=%0d of %0d checks", r_errs, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
